// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable down-counter timer with expiry pulse and auto-reload
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             done_d;

    // State, count, reload value and done pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count    <= '0;
            reload_q <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            reload_q <= reload_d;
            done     <= done_d;
        end
    end

    // Next-state and datapath: loads in IDLE, abort > en in RUN, expiry at count 1
    always_comb begin
        state_d  = state_q;
        count_d  = count;
        reload_d = reload_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_valid && load_ready) begin
                    reload_d = load_value;
                    if (load_value != '0) begin
                        count_d = load_value;
                        state_d = RUN;
                    end else begin
                        // zero-length timer expires immediately without entering RUN
                        count_d = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (en) begin
                    if (count > ONE) begin
                        count_d = count - ONE;
                    end else begin
                        // count is never 0 in RUN, so this is the expiry from 1
                        done_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy       = (state_q == RUN);
        load_ready = (state_q == IDLE) && !rst;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counter timer, the counterpart to the free-running up-counter.
- Takes a start value through a valid/ready load handshake and decrements once per enabled cycle.
- Pulses done on expiry, with optional auto-reload for periodic ticks.
- Used as the timeout and periodic-event source next to the existing counter in the same clock domain.

Parameters:
WIDTH, 8, width of load value and count.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
load_valid  input  1  load request; load_value is valid.
load_ready  output  1  timer accepts a load this cycle (high only in IDLE, low during rst).
load_value  input  WIDTH  start value; captured on handshake.
en  input  1  decrement enable; 0 pauses the count.
auto_reload  input  1  sampled at each expiry; 1 restarts from the last loaded value.
abort  input  1  cancel the running count.
count  output  WIDTH  current remaining count (registered).
busy  output  1  high in RUN.
done  output  1  one-cycle expiry pulse (registered).

Behaviour:
- Reset:
  - rst sampled high at a rising edge gives: state=IDLE, count=0, reload_reg=0, busy=0, done=0.
  - load_ready is 0 while rst is high.
  - Reset mid-RUN abandons the count with no done pulse.
- States: IDLE, RUN. busy = (state==RUN). load_ready = (state==IDLE) && !rst, combinational from state.
- IDLE:
  - Handshake (load_valid && load_ready) with load_value!=0 gives: count<=load_value, reload_reg<=load_value, state<=RUN.
  - Handshake with load_value==0 gives: zero-length timer. done<=1 next edge, state stays IDLE, count stays 0, reload_reg<=0.
  - en, abort and auto_reload are ignored in IDLE.
- RUN, priority abort > en:
  - abort=1: count<=0, state<=IDLE, done<=0.
  - en=0: count holds.
  - en=1 and count>1: count<=count-1.
  - en=1 and count==1 (expiry): done<=1.
    - auto_reload=1: count<=reload_reg, stay RUN.
    - auto_reload=0: count<=0, state<=IDLE.
  - load_valid is ignored in RUN (load_ready=0). A pending load_valid is accepted on the first IDLE cycle.
- done:
  - Asserted for exactly one cycle, in the cycle following the expiry edge. It deasserts the next edge unless another expiry occurs.
  - Back-to-back pulses are legal: reload value 1 with en and auto_reload held gives done high every cycle.
- Latency:
  - Load value N with en held high: count reads N, N-1, …, 1 over N cycles.
  - done is high after the Nth enabled edge, i.e. N cycles after the load edge.
  - Cycles with en=0 add one cycle each.
- Arithmetic:
  - Unsigned WIDTH-bit. No wrap: count never decrements below 0, because expiry from 1 goes to 0 or reload.
  - Max load 2^WIDTH-1 (255) is legal.
- Simultaneous events:
  - Expiry and abort in the same cycle: abort wins, no done.
  - Expiry in non-reload mode: state returns to IDLE on that edge, so a load can be accepted on the very next cycle, while done is high.

Test Plan:
- Reset, then load 5 with en=1, auto_reload=0 → count 5,4,3,2,1; done high for one cycle after the 5th enabled edge; count=0, busy=0, load_ready=1.
- Load 5, en=1 for 2 cycles, en=0 for 3 cycles, en=1 → count holds at 3 during pause; done appears 3 enabled cycles after resume; total 8 cycles from load.
- Load 3 with auto_reload=1, en=1 for 9 cycles → done pulses every 3rd cycle (3 pulses); count cycles 3,2,1,3,2,1…; busy stays 1; load_valid during RUN not accepted (load_ready=0).
- Load 200, run 10 cycles (count=190), assert rst one cycle → count=0, busy=0, done=0, and no done pulse afterwards. Then load 0 → done pulses once next cycle, busy stays 0.
- Load 4, abort at count==1 with en=1 → count=0, IDLE, no done. Load 255 → count=254 after one enabled cycle.
- Load 2 (auto_reload=0) with load_valid held high with value 7 → expires, done=1 concurrently with acceptance of 7 on the first IDLE cycle; count=7 next cycle.
